// File: rtl/cpu_types_pkg.sv
// Shared CPU types: memory arbiter state and starvation limit defaults.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      IDLE,
      I_ACC,
      D_ACC
   } arb_state_t;

   localparam int ARB_STARVE_DEFAULT = 4;

   function automatic int starve_w(input int lim);
      return $clog2(lim + 1);
   endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of lost instruction-side arbitrations.
module starve_counter
   import cpu_types_pkg::*;
#(
   parameter int LIMIT = ARB_STARVE_DEFAULT
) (
   input  logic CLK,
   input  logic nRST,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int W = starve_w(LIMIT);
   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign sat = (cnt_q == LIM);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && !sat)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single RAM port arbiter: data side has priority, instruction side
// is forced through after STARVE_LIMIT consecutive lost arbitrations.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = ARB_STARVE_DEFAULT,
   parameter int ADDR_W       = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [ADDR_W-1:0] iload,
   output logic              iwait,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [ADDR_W-1:0] dstore,
   output logic [ADDR_W-1:0] dload,
   output logic              dwait,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [ADDR_W-1:0] ramstore,
   input  logic [ADDR_W-1:0] ramload,
   input  logic              ram_ready
);

   arb_state_t state_q, state_d;
   logic       wr_q, wr_d;
   logic       dreq;
   logic       inc, clr, sat;

   assign dreq  = dREN | dWEN;
   assign iload = ramload;
   assign dload = ramload;

   starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
      .CLK  (CLK),
      .nRST (nRST),
      .inc  (inc),
      .clr  (clr),
      .sat  (sat)
   );

   always_comb begin
      state_d  = state_q;
      wr_d     = wr_q;
      inc      = 1'b0;
      clr      = 1'b0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (dreq && !(iREN && sat)) begin
               state_d = D_ACC;
               wr_d    = dWEN;
               inc     = iREN;
               clr     = !iREN;
            end else begin
               clr = 1'b1;
               if (iREN)
                  state_d = I_ACC;
            end
         end
         I_ACC: begin
            if (!iREN) begin
               state_d = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ram_ready) begin
                  iwait   = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         D_ACC: begin
            if (!dreq) begin
               state_d = IDLE;
            end else begin
               ramWEN   = wr_q;
               ramREN   = !wr_q;
               ramaddr  = daddr;
               ramstore = dstore;
               if (ram_ready) begin
                  dwait   = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int LIMIT = 4;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          iREN = 1'b0;
   logic [AW-1:0] iaddr = '0;
   logic [AW-1:0] iload;
   logic          iwait;
   logic          dREN = 1'b0;
   logic          dWEN = 1'b0;
   logic [AW-1:0] daddr = '0;
   logic [AW-1:0] dstore = '0;
   logic [AW-1:0] dload;
   logic          dwait;
   logic          ramREN;
   logic          ramWEN;
   logic [AW-1:0] ramaddr;
   logic [AW-1:0] ramstore;
   logic [AW-1:0] ramload = '0;
   logic          ram_ready = 1'b0;

   int total = 0;
   int bad = 0;

   int m_own = 0;
   bit m_wr = 1'b0;
   int m_lost = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) u_dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .iload     (iload),
      .iwait     (iwait),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .daddr     (daddr),
      .dstore    (dstore),
      .dload     (dload),
      .dwait     (dwait),
      .ramREN    (ramREN),
      .ramWEN    (ramWEN),
      .ramaddr   (ramaddr),
      .ramstore  (ramstore),
      .ramload   (ramload),
      .ram_ready (ram_ready)
   );

   task automatic clr_inputs();
      iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
   endtask

   task automatic do_reset();
      clr_inputs();
      nRST = 0;
      m_own = 0; m_wr = 0; m_lost = 0;
      @(posedge CLK);
      @(negedge CLK);
      nRST = 1;
   endtask

   task automatic next_cyc();
      @(posedge CLK);
      #1;
   endtask

   // Owner-level reference: who holds the port and how many I losses.
   task automatic model_step();
      bit ireq, dq;
      ireq = iREN;
      dq = dREN | dWEN;
      if (m_own == 0) begin
         if (ireq && dq && m_lost >= LIMIT) begin
            m_own = 1; m_lost = 0;
         end else if (dq) begin
            m_own = 2; m_wr = dWEN;
            m_lost = ireq ? ((m_lost + 1 > LIMIT) ? LIMIT : m_lost + 1) : 0;
         end else begin
            m_own = ireq ? 1 : 0;
            m_lost = 0;
         end
      end else if (m_own == 1) begin
         if (!ireq || ram_ready) m_own = 0;
      end else begin
         if (!dq || ram_ready) m_own = 0;
      end
   endtask

   task automatic model_expect(output logic e_ren, output logic e_wen,
                               output logic [AW-1:0] e_addr,
                               output logic [AW-1:0] e_store,
                               output logic e_iw, output logic e_dw);
      e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0; e_iw = 1; e_dw = 1;
      if (m_own == 1 && iREN) begin
         e_ren = 1; e_addr = iaddr;
         if (ram_ready) e_iw = 0;
      end else if (m_own == 2 && (dREN || dWEN)) begin
         e_wen = m_wr; e_ren = !m_wr; e_addr = daddr; e_store = dstore;
         if (ram_ready) e_dw = 0;
      end
   endtask

   task automatic test_reset();
      clr_inputs();
      nRST = 0;
      ramload = 32'hA5A5_0F0F;
      #2;
      total++; if ({ramREN, ramWEN} !== 2'b00) begin bad++;
         $display("FAIL reset_strobes got=%b exp=00", {ramREN, ramWEN}); end
      total++; if (ramaddr !== '0 || ramstore !== '0) begin bad++;
         $display("FAIL reset_addr got=%h/%h exp=0", ramaddr, ramstore); end
      total++; if ({iwait, dwait} !== 2'b11) begin bad++;
         $display("FAIL reset_wait got=%b exp=11", {iwait, dwait}); end
      total++; if (iload !== 32'hA5A5_0F0F || dload !== 32'hA5A5_0F0F) begin bad++;
         $display("FAIL reset_load got=%h/%h exp=a5a50f0f", iload, dload); end
      do_reset();
   endtask

   task automatic test_iread();
      do_reset();
      iREN = 1; iaddr = 32'h40;
      #2;
      total++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin bad++;
         $display("FAIL iread_c0 got=%b%b exp=01", ramREN, iwait); end
      next_cyc();
      ram_ready = 1; ramload = 32'hDEAD_BEEF;
      #2;
      total++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin bad++;
         $display("FAIL iread_c1_ram got=%b/%h exp=1/40", ramREN, ramaddr); end
      total++; if (iwait !== 1'b0 || iload !== 32'hDEAD_BEEF) begin bad++;
         $display("FAIL iread_c1_data got=%b/%h exp=0/deadbeef", iwait, iload); end
      next_cyc();
      #2;
      total++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin bad++;
         $display("FAIL iread_c2_idle got=%b%b exp=01", ramREN, iwait); end
   endtask

   task automatic test_simul();
      do_reset();
      iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100; ram_ready = 1;
      next_cyc();
      #2;
      total++; if (ramaddr !== 32'h100 || dwait !== 1'b0 || iwait !== 1'b1) begin bad++;
         $display("FAIL simul_d got=%h/%b%b exp=100/01", ramaddr, dwait, iwait); end
      next_cyc();
      dREN = 0;
      #2;
      total++; if (ramREN !== 1'b0) begin bad++;
         $display("FAIL simul_turn got=%b exp=0", ramREN); end
      next_cyc();
      #2;
      total++; if (ramaddr !== 32'h44 || iwait !== 1'b0 || dwait !== 1'b1) begin bad++;
         $display("FAIL simul_i got=%h/%b%b exp=44/01", ramaddr, iwait, dwait); end
   endtask

   task automatic test_starve();
      int d_cnt;
      int got_i;
      do_reset();
      iREN = 1; dREN = 1; ram_ready = 1;
      iaddr = 32'h80; daddr = 32'h180;
      d_cnt = 0; got_i = -1;
      for (int g = 0; g < 6; g++) begin
         next_cyc();
         #2;
         if (dwait === 1'b0 && got_i < 0) d_cnt++;
         if (iwait === 1'b0 && got_i < 0) got_i = g;
         if (g == 5) begin
            total++; if (dwait !== 1'b0) begin bad++;
               $display("FAIL starve_after_i got=%b exp=0", dwait); end
         end
         next_cyc();
      end
      total++; if (d_cnt !== LIMIT) begin bad++;
         $display("FAIL starve_dcount got=%0d exp=%0d", d_cnt, LIMIT); end
      total++; if (got_i !== LIMIT) begin bad++;
         $display("FAIL starve_igrant got=%0d exp=%0d", got_i, LIMIT); end
   endtask

   task automatic test_write_wait();
      do_reset();
      dWEN = 1; daddr = 32'h200; dstore = 32'h1234_5678;
      next_cyc();
      for (int k = 1; k <= 4; k++) begin
         ram_ready = (k == 4);
         #2;
         total++;
         if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234_5678 ||
             ramaddr !== 32'h200 || iwait !== 1'b1 || dwait !== (k != 4)) begin
            bad++;
            $display("FAIL wr_wait_c%0d got=%b%b/%h/%h/%b%b", k, ramWEN, ramREN,
                     ramaddr, ramstore, iwait, dwait);
         end
         next_cyc();
      end
      ram_ready = 0;
      #2;
      total++; if (ramWEN !== 1'b0) begin bad++;
         $display("FAIL wr_wait_done got=%b exp=0", ramWEN); end
   endtask

   task automatic test_abort();
      do_reset();
      dREN = 1; daddr = 32'h300;
      next_cyc();
      #2;
      total++; if (ramREN !== 1'b1) begin bad++;
         $display("FAIL abort_c1 got=%b exp=1", ramREN); end
      next_cyc();
      dREN = 0;
      #2;
      total++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin bad++;
         $display("FAIL abort_c2 got=%b%b exp=01", ramREN, dwait); end
      next_cyc();
      ram_ready = 1;
      #2;
      total++; if (ramREN !== 1'b0 || dwait !== 1'b1 || iwait !== 1'b1) begin bad++;
         $display("FAIL abort_c3 got=%b%b%b exp=011", ramREN, dwait, iwait); end
      next_cyc();
      ram_ready = 0; dREN = 1; dWEN = 1; dstore = 32'h0BAD_F00D;
      next_cyc();
      #2;
      total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin bad++;
         $display("FAIL both_strobe got=%b%b exp=10", ramWEN, ramREN); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      iREN = 1; iaddr = 32'h500;
      next_cyc();
      #2;
      total++; if (ramREN !== 1'b1) begin bad++;
         $display("FAIL rstmid_pre got=%b exp=1", ramREN); end
      nRST = 0;
      #1;
      total++; if (ramREN !== 1'b0 || {iwait, dwait} !== 2'b11) begin bad++;
         $display("FAIL rstmid_drop got=%b/%b exp=0/11", ramREN, {iwait, dwait}); end
      iREN = 1; dREN = 1; daddr = 32'h600;
      @(negedge CLK);
      nRST = 1;
      next_cyc();
      #2;
      total++; if (ramaddr !== 32'h600 || ramREN !== 1'b1) begin bad++;
         $display("FAIL rstmid_cnt0 got=%h/%b exp=600/1", ramaddr, ramREN); end
   endtask

   task automatic test_random();
      logic          e_ren, e_wen, e_iw, e_dw;
      logic [AW-1:0] e_addr, e_store;
      int            errs;
      do_reset();
      errs = 0;
      for (int c = 0; c < 600; c++) begin
         iREN = ($urandom_range(0, 3) != 0);
         dREN = ($urandom_range(0, 2) != 0);
         dWEN = ($urandom_range(0, 3) == 0);
         ram_ready = $urandom_range(0, 1);
         iaddr = $urandom; daddr = $urandom;
         dstore = $urandom; ramload = $urandom;
         #2;
         model_expect(e_ren, e_wen, e_addr, e_store, e_iw, e_dw);
         total++;
         if (ramREN !== e_ren || ramWEN !== e_wen || ramaddr !== e_addr ||
             ramstore !== e_store || iwait !== e_iw || dwait !== e_dw ||
             iload !== ramload || dload !== ramload) begin
            bad++;
            errs++;
            if (errs < 10)
               $display("FAIL rand_c%0d got=%b%b/%h/%h/%b%b exp=%b%b/%h/%h/%b%b",
                        c, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait,
                        e_ren, e_wen, e_addr, e_store, e_iw, e_dw);
         end
         @(posedge CLK);
         model_step();
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_iread();
      test_simul();
      test_starve();
      test_write_wait();
      test_abort();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
